// File: rtl/if_id_skid_pkg.sv
// rtl/if_id_skid_pkg.sv - shared pipeline constants and slot state encoding for the IF/ID skid buffer
package if_id_skid_pkg;

    // Default payload widths shared by every pipeline register stage.
    localparam int DEF_ADDR_W = 32;
    localparam int DEF_INST_W = 32;
    localparam int DEF_SB_W   = 4;

    // Fill bit for a bubble payload: an all-zero instruction decodes as a NOP.
    localparam logic ZERO_FILL = 1'b0;

    // Number of held entries; the encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

endpackage

// File: rtl/pipe_slot.sv
// rtl/pipe_slot.sv - single payload register with load and synchronous clear
module pipe_slot
    import if_id_skid_pkg::*;
#(
    parameter int W = DEF_ADDR_W + DEF_INST_W + DEF_SB_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Clear wins over load so a redirect can never leave a stale entry behind.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= {W{ZERO_FILL}};
        end else if (clear) begin
            q <= {W{ZERO_FILL}};
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/if_id_skid.sv
// rtl/if_id_skid.sv - two-entry IF/ID skid buffer with registered upstream ready
module if_id_skid
    import if_id_skid_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int INST_W = DEF_INST_W,
    parameter int SB_W   = DEF_SB_W      // must be at least 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              up_valid,
    output logic              up_ready,
    input  logic [ADDR_W-1:0] up_pc,
    input  logic [INST_W-1:0] up_inst,
    input  logic [SB_W-1:0]   up_sb,
    output logic              dn_valid,
    input  logic              dn_ready,
    output logic [ADDR_W-1:0] dn_pc,
    output logic [INST_W-1:0] dn_inst,
    output logic [SB_W-1:0]   dn_sb,
    output logic [1:0]        occupancy
);

    localparam int PAY_W = ADDR_W + INST_W + SB_W;

    state_t             state;
    state_t             state_nxt;
    logic               up_ready_q;
    logic               up_ready_nxt;
    logic               up_xfer;
    logic               dn_xfer;
    logic [PAY_W-1:0]   up_pay;
    logic [PAY_W-1:0]   main_q;
    logic [PAY_W-1:0]   skid_q;
    logic [PAY_W-1:0]   main_d;
    logic               main_load;
    logic               main_clr;
    logic               skid_load;
    logic               skid_clr;

    assign up_pay    = {up_pc, up_inst, up_sb};
    assign up_ready  = up_ready_q;
    assign up_xfer   = up_valid & up_ready_q;
    assign dn_valid  = (state != ST_EMPTY);
    assign dn_xfer   = dn_valid & dn_ready;
    assign occupancy = state;

    // MAIN is zeroed whenever the buffer empties, so dn_* reads as a NOP bubble then.
    assign {dn_pc, dn_inst, dn_sb} = main_q;

    // State and registered ready; ready depends only on the next state, never on dn_ready directly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_EMPTY;
            up_ready_q <= 1'b0;
        end else begin
            state      <= state_nxt;
            up_ready_q <= up_ready_nxt;
        end
    end

    // Next state and slot steering; flush overrides every transfer.
    always_comb begin
        state_nxt = state;
        main_d    = up_pay;
        main_load = 1'b0;
        main_clr  = 1'b0;
        skid_load = 1'b0;
        skid_clr  = 1'b0;

        if (flush) begin
            state_nxt = ST_EMPTY;
            main_clr  = 1'b1;
            skid_clr  = 1'b1;
        end else begin
            unique case (state)
                ST_EMPTY: begin
                    if (up_xfer) begin
                        main_load = 1'b1;
                        state_nxt = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (up_xfer && !dn_xfer) begin
                        skid_load = 1'b1;
                        state_nxt = ST_FULL;
                    end else if (up_xfer && dn_xfer) begin
                        main_load = 1'b1;
                    end else if (dn_xfer) begin
                        main_clr  = 1'b1;
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    // up_ready is low here, so only the drain side can move.
                    if (dn_xfer) begin
                        main_d    = skid_q;
                        main_load = 1'b1;
                        skid_clr  = 1'b1;
                        state_nxt = ST_ONE;
                    end
                end
                default: begin
                    state_nxt = ST_EMPTY;
                    main_clr  = 1'b1;
                    skid_clr  = 1'b1;
                end
            endcase
        end

        up_ready_nxt = (state_nxt != ST_FULL);
    end

    pipe_slot #(.W(PAY_W)) u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_load),
        .clear (main_clr),
        .d     (main_d),
        .q     (main_q)
    );

    pipe_slot #(.W(PAY_W)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_load),
        .clear (skid_clr),
        .d     (up_pay),
        .q     (skid_q)
    );

endmodule

// File: tb/tb_if_id_skid.sv
// tb/tb_if_id_skid.sv - self-checking bench for if_id_skid, default and wide/narrow payload instances
module tb_if_id_skid;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [3:0]  sb;
    } ent_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush = 1'b0;
    logic        up_valid = 1'b0;
    logic        dn_ready = 1'b0;
    logic [63:0] cur_pc = '0;
    logic [31:0] cur_inst = '0;
    logic [3:0]  cur_sb = '0;

    logic        up_ready, dn_valid;
    logic [31:0] dn_pc, dn_inst;
    logic [3:0]  dn_sb;
    logic [1:0]  occupancy;

    logic        w_up_ready, w_dn_valid;
    logic [63:0] w_dn_pc;
    logic [15:0] w_dn_inst;
    logic [0:0]  w_dn_sb;
    logic [1:0]  w_occupancy;

    int   checks = 0;
    int   errors = 0;
    ent_t q[$];
    bit   exp_ready = 1'b0;

    always #5 clk = ~clk;

    if_id_skid dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .up_valid  (up_valid),
        .up_ready  (up_ready),
        .up_pc     (cur_pc[31:0]),
        .up_inst   (cur_inst),
        .up_sb     (cur_sb),
        .dn_valid  (dn_valid),
        .dn_ready  (dn_ready),
        .dn_pc     (dn_pc),
        .dn_inst   (dn_inst),
        .dn_sb     (dn_sb),
        .occupancy (occupancy)
    );

    if_id_skid #(.ADDR_W(64), .INST_W(16), .SB_W(1)) dut_w (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .up_valid  (up_valid),
        .up_ready  (w_up_ready),
        .up_pc     (cur_pc),
        .up_inst   (cur_inst[15:0]),
        .up_sb     (cur_sb[0:0]),
        .dn_valid  (w_dn_valid),
        .dn_ready  (dn_ready),
        .dn_pc     (w_dn_pc),
        .dn_inst   (w_dn_inst),
        .dn_sb     (w_dn_sb),
        .occupancy (w_occupancy)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic offer(input logic [31:0] pc_lo);
        up_valid = 1'b1;
        cur_pc   = {$urandom(), pc_lo};
        cur_inst = $urandom();
        cur_sb   = 4'($urandom());
    endtask

    // Compare both instances with the queue model, then advance one clock and update the model.
    task automatic cycle();
        ent_t h;
        bit   upf, dnf;
        h = (q.size() != 0) ? q[0] : '0;
        chk("dn_valid",    64'(dn_valid),    64'(q.size() != 0));
        chk("occupancy",   64'(occupancy),   64'(q.size()));
        chk("up_ready",    64'(up_ready),    64'(exp_ready));
        chk("dn_pc",       64'(dn_pc),       64'(h.pc[31:0]));
        chk("dn_inst",     64'(dn_inst),     64'(h.inst));
        chk("dn_sb",       64'(dn_sb),       64'(h.sb));
        chk("w_dn_valid",  64'(w_dn_valid),  64'(q.size() != 0));
        chk("w_occupancy", 64'(w_occupancy), 64'(q.size()));
        chk("w_up_ready",  64'(w_up_ready),  64'(exp_ready));
        chk("w_dn_pc",     w_dn_pc,          h.pc);
        chk("w_dn_inst",   64'(w_dn_inst),   64'(h.inst[15:0]));
        chk("w_dn_sb",     64'(w_dn_sb),     64'(h.sb[0]));
        upf = up_valid && exp_ready;
        dnf = (q.size() != 0) && dn_ready;
        @(posedge clk);
        if (!rst) begin
            q.delete();
            exp_ready = 1'b0;
        end else begin
            if (flush) begin
                q.delete();
            end else begin
                if (dnf) void'(q.pop_front());
                if (upf) q.push_back('{pc: cur_pc, inst: cur_inst, sb: cur_sb});
            end
            exp_ready = (q.size() < 2);
        end
        @(negedge clk);
        #1;
    endtask

    initial begin
        // Reset held across a couple of edges.
        @(negedge clk); #1;
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        chk("ready_after_release", 64'(up_ready), 64'd1);

        // Back-to-back streaming with ID always ready.
        dn_ready = 1'b1;
        offer(32'h100); cycle();
        chk("stream_first", 64'(dn_pc), 64'h100);
        offer(32'h104); cycle();
        chk("stream_second", 64'(dn_pc), 64'h104);
        offer(32'h108); cycle();
        chk("stream_third", 64'(dn_pc), 64'h108);
        chk("stream_occ", 64'(occupancy), 64'd1);
        up_valid = 1'b0; cycle();

        // ID stall fills both slots; 0x208 waits at the input.
        dn_ready = 1'b0;
        offer(32'h200); cycle();
        offer(32'h204); cycle();
        offer(32'h208); cycle();
        chk("stall_occ", 64'(occupancy), 64'd2);
        chk("stall_ready", 64'(up_ready), 64'd0);
        chk("stall_head", 64'(w_dn_pc[31:0]), 64'h200);
        cycle();
        dn_ready = 1'b1; cycle();
        chk("stall_drain_204", 64'(dn_pc), 64'h204);
        cycle();
        up_valid = 1'b0;
        chk("stall_drain_208", 64'(dn_pc), 64'h208);
        cycle();
        cycle();

        // Flush while full, with a new entry offered in the same cycle.
        dn_ready = 1'b0;
        offer(32'h300); cycle();
        offer(32'h304); cycle();
        flush = 1'b1; offer(32'h308); cycle();
        flush = 1'b0; up_valid = 1'b0;
        chk("flush_occ", 64'(occupancy), 64'd0);
        chk("flush_valid", 64'(dn_valid), 64'd0);
        chk("flush_pc", 64'(dn_pc), 64'd0);
        dn_ready = 1'b1; cycle(); cycle();

        // Simultaneous push and pop while holding one entry.
        dn_ready = 1'b0;
        offer(32'h400); cycle();
        dn_ready = 1'b1; offer(32'h404); cycle();
        up_valid = 1'b0; dn_ready = 1'b0;
        chk("simul_pc", 64'(dn_pc), 64'h404);
        chk("simul_occ", 64'(occupancy), 64'd1);
        dn_ready = 1'b1; cycle(); cycle();

        // Asynchronous reset mid-cycle while full.
        dn_ready = 1'b0;
        offer(32'h500); cycle();
        offer(32'h504); cycle();
        up_valid = 1'b0;
        chk("pre_reset_occ", 64'(occupancy), 64'd2);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_valid", 64'(dn_valid), 64'd0);
        chk("async_rst_occ", 64'(occupancy), 64'd0);
        chk("async_rst_inst", 64'(dn_inst), 64'd0);
        chk("async_rst_ready", 64'(up_ready), 64'd0);
        chk("async_rst_w_pc", w_dn_pc, 64'd0);
        q.delete();
        exp_ready = 1'b0;
        @(negedge clk); #1;
        rst = 1'b1;
        cycle();
        chk("ready_one_edge_after", 64'(up_ready), 64'd1);

        // Randomised traffic against the queue model.
        for (int i = 0; i < 400; i++) begin
            up_valid = 1'($urandom_range(0, 3) != 0);
            cur_pc   = {$urandom(), $urandom()};
            cur_inst = $urandom();
            cur_sb   = 4'($urandom());
            dn_ready = 1'($urandom_range(0, 2) != 0);
            flush    = 1'($urandom_range(0, 15) == 0);
            cycle();
        end
        flush = 1'b0; up_valid = 1'b0; dn_ready = 1'b1;
        cycle(); cycle(); cycle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_id_skid.md
IF_ID_SKID -- requirements
Module: if_id_skid

Interface
REQ-001 Parameter ADDR_W, default 32, SHALL set the instruction-address (PC) width.
REQ-002 Parameter INST_W, default 32, SHALL set the instruction word width.
REQ-003 Parameter SB_W, default 4, SHALL set the sideband width (fetch exception/predecode flags), minimum 1.
REQ-004 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-005 rst  input  1  SHALL be the asynchronous, active-low reset.
REQ-006 flush  input  1  SHALL be the synchronous kill of all held entries (branch/exception redirect).
REQ-007 up_valid  input  1  SHALL indicate the IF stage presents a valid entry.
REQ-008 up_ready  output  1  SHALL indicate the block accepts an entry this cycle.
REQ-009 up_pc / up_inst / up_sb  input  ADDR_W / INST_W / SB_W  SHALL be the IF-side payload.
REQ-010 dn_valid  output  1  SHALL indicate a valid entry is presented to ID.
REQ-011 dn_ready  input  1  SHALL indicate ID consumes the presented entry this cycle (low = ID stall).
REQ-012 dn_pc / dn_inst / dn_sb  output  ADDR_W / INST_W / SB_W  SHALL be the ID-side payload.
REQ-013 occupancy  output  2  SHALL report the number of held entries (0, 1 or 2).

Function
REQ-014 An up-transfer SHALL occur when up_valid and up_ready are both high; a down-transfer SHALL occur when dn_valid and dn_ready are both high.
REQ-015 The block SHALL hold two registered slots, MAIN (drives dn_*) and SKID, under a state machine EMPTY(0), ONE(1), FULL(2), equal to occupancy.
REQ-016 up_ready SHALL be a registered output, high exactly when state is not FULL, with no combinational path from dn_ready.
REQ-017 dn_valid SHALL be high exactly when state is ONE or FULL; dn_* SHALL be driven only from the MAIN slot.
REQ-018 Latency SHALL be one cycle: an entry accepted into an EMPTY block is presented on dn_* in the next cycle.
REQ-019 EMPTY: an up-transfer SHALL load MAIN and move to ONE; otherwise the state SHALL hold.
REQ-020 ONE: up-transfer with no down-transfer SHALL load SKID and move to FULL; both transfers SHALL reload MAIN and stay in ONE; a down-transfer only SHALL clear MAIN and move to EMPTY.
REQ-021 FULL: a down-transfer SHALL copy SKID to MAIN, clear SKID and move to ONE; no up-transfer is possible.
REQ-022 Entry order SHALL be strictly FIFO; no entry SHALL be duplicated or dropped except by flush.
REQ-023 flush SHALL have priority over all transfers: next state EMPTY, both slots cleared to zero, and any entry offered that cycle discarded.
REQ-024 A down-transfer coinciding with flush SHALL still count as consumed by ID; the block need not suppress it.
REQ-025 Whenever state is EMPTY, dn_pc, dn_inst and dn_sb SHALL read all-zero (zero instruction = NOP bubble).
REQ-026 With dn_ready held high and up_valid high every cycle, throughput SHALL be one entry per cycle with occupancy constant at 1.

Reset
REQ-027 Assertion of rst SHALL immediately force state EMPTY, occupancy 0, dn_valid 0, up_ready 0, and clear both slots to zero, regardless of clk.
REQ-028 up_ready SHALL rise on the first rising edge after rst deasserts; an entry in flight at reset SHALL be lost without side effects.

Structure
REQ-029 State encoding (EMPTY/ONE/FULL) and the ZERO payload constant SHALL live in the shared pipeline package/define file, with default widths as shared constants.
REQ-030 One sub-module, pipe_slot (ADDR_W+INST_W+SB_W register with load and synchronous clear, async active-low reset), SHALL be instantiated twice for MAIN and SKID.

Verification
REQ-031 Reset: assert rst mid-cycle with state FULL -> dn_valid=0, occupancy=0, dn_inst=0x00000000 without a clock edge; up_ready=1 one edge after release.
REQ-032 Streaming: pc 0x100,0x104,0x108 offered back-to-back with dn_ready=1 -> dn_pc 0x100,0x104,0x108 on consecutive cycles, each one cycle late, occupancy=1.
REQ-033 Stall: dn_ready=0 while 0x200,0x204 are offered -> occupancy 2, up_ready=0; 0x208 held at input; dn_ready=1 -> 0x200,0x204,0x208 delivered in order.
REQ-034 Flush: FULL with 0x300/0x304, flush=1 together with up_valid carrying 0x308 -> next cycle occupancy=0, dn_valid=0, dn_pc=0; 0x308 never appears.
REQ-035 Simultaneous: state ONE (0x400), up 0x404 and dn_ready=1 in the same cycle -> 0x400 consumed, dn_pc=0x404, occupancy stays 1.
REQ-036 Width: instantiate with ADDR_W=64, INST_W=16, SB_W=1; repeat REQ-033 -> payload bits intact end to end.
